// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator. Walks two captured operands MSB-first, one bit pair per clock,
// latches the first non-equal decision and reports a one-hot registered result with a done pulse.
module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IW-1:0]    idx;
    logic             dec_gt, dec_lt;

    logic bit_gt, bit_lt, decided, new_gt, new_lt, finish, accept;

    // 1-bit comparator cell on the current bit pair; an earlier decision masks it.
    always_comb begin
        bit_gt  = a_r[idx] & ~b_r[idx];
        bit_lt  = ~a_r[idx] & b_r[idx];
        decided = dec_gt | dec_lt;
        new_gt  = dec_gt | (~decided & bit_gt);
        new_lt  = dec_lt | (~decided & bit_lt);
        finish  = (idx == '0) || (EARLY_EXIT && (bit_gt || bit_lt));
        accept  = start && (state != SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            idx    <= '0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_eq_b <= 1'b0;
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        a_r    <= a;
                        b_r    <= b;
                        idx    <= IW'(WIDTH - 1);
                        dec_gt <= 1'b0;
                        dec_lt <= 1'b0;
                        busy   <= 1'b1;
                        a_eq_b <= 1'b0;
                        a_gt_b <= 1'b0;
                        a_lt_b <= 1'b0;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    if (finish) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        a_gt_b <= new_gt;
                        a_lt_b <= new_lt;
                        a_eq_b <= ~(new_gt | new_lt);
                        state  <= DONE;
                    end else begin
                        idx    <= idx - 1'b1;
                        dec_gt <= new_gt;
                        dec_lt <= new_lt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
